// File: rtl/freq_meter_mc_if.sv
// Result stream of the multi-channel frequency meter: one {channel, sig_cnt,
// ref_cnt, flags} record per valid/ready handshake.
interface freq_meter_mc_if #(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 32
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                 res_valid_o;
  logic                 res_ready_i;
  logic [CH_W-1:0]      res_ch_o;
  logic [CNT_WIDTH-1:0] res_sig_o;
  logic [CNT_WIDTH-1:0] res_ref_o;
  logic [1:0]           res_flags_o;

  modport master (
    output res_valid_o, res_ch_o, res_sig_o, res_ref_o, res_flags_o,
    input  res_ready_i
  );

  modport slave (
    input  res_valid_o, res_ch_o, res_sig_o, res_ref_o, res_flags_o,
    output res_ready_i
  );
endinterface

// File: rtl/freq_meter_mc.sv
// Multi-channel reciprocal frequency meter. Every channel opens its gate on a
// signal edge and closes it on the first edge at least G cycles later, so both
// counts span whole signal periods. Results are drained in channel order.
// Optional build macro MEASURE_TIMEOUT_EN adds a per-channel dead-input timeout.
//
// Top FSM
//   state | meaning
//   IDLE  | waiting for start_i
//   GATE  | channels measuring, waiting for all of them to finish
//   DRAIN | presenting results ch0..CHANNELS-1, one per handshake
//
// Channel FSM
//   state   | meaning
//   C_IDLE  | inactive
//   C_ARM   | waiting for the opening edge
//   C_OPEN  | counting, gate length not yet reached
//   C_CLOSE | counting, next edge closes the gate
//   C_DONE  | result frozen, waiting for drain
module freq_meter_mc #(
  parameter int CHANNELS       = 4,
  parameter int CNT_WIDTH      = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [CHANNELS-1:0]  sig_i,
  input  logic [CNT_WIDTH-1:0] gate_time_i,
  input  logic                 start_i,
  input  logic                 cont_i,
  input  logic                 stop_i,
  output logic                 busy_o,
  freq_meter_mc_if.master      res
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, GATE, DRAIN} top_state_t;
  typedef enum logic [2:0] {C_IDLE, C_ARM, C_OPEN, C_CLOSE, C_DONE} ch_state_t;

  if (CHANNELS < 1 || CHANNELS > 16 || SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("freq_meter_mc: illegal parameter value");
  end

  top_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] gate_q;
  logic [CH_W-1:0]      rd_ch_q;
  logic                 arm;
  logic                 abort;
  logic                 accept;
  logic                 last_ch;

  logic [CHANNELS-1:0]  ch_done;
  logic [CNT_WIDTH-1:0] ch_sig   [CHANNELS];
  logic [CNT_WIDTH-1:0] ch_ref   [CHANNELS];
  logic [1:0]           ch_flags [CHANNELS];

  assign abort   = stop_i;
  assign accept  = (state_q == DRAIN) && res.res_ready_i;
  assign last_ch = (rd_ch_q == CH_W'(CHANNELS - 1));

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_prev_q;
    logic                   sig_edge;
    ch_state_t              c_state_q, c_state_d;
    logic [CNT_WIDTH-1:0]   sig_cnt_q;
    logic [CNT_WIDTH-1:0]   ref_cnt_q;
    logic                   ovf_q;
    logic                   tmo_q;
    logic                   measuring;
    logic                   gate_met;
    logic                   closing;
    logic                   timed_out;

    // Synchroniser chain plus one delay flop for rising-edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sync_q     <= '0;
        sig_prev_q <= 1'b0;
      end else begin
        sync_q     <= {sync_q[SYNC_STAGES-2:0], sig_i[c]};
        sig_prev_q <= sync_q[SYNC_STAGES-1];
      end
    end

    assign sig_edge  = sync_q[SYNC_STAGES-1] & ~sig_prev_q;
    assign measuring = (c_state_q == C_ARM) || (c_state_q == C_OPEN) || (c_state_q == C_CLOSE);
    // ref_cnt_q holds t - t0 while the gate is open, so an edge seen with
    // ref_cnt_q >= G is the closing edge (including exactly G).
    assign gate_met  = (ref_cnt_q >= gate_q);
    assign closing   = sig_edge && gate_met && ((c_state_q == C_OPEN) || (c_state_q == C_CLOSE));

`ifdef MEASURE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q;

    // Timeout counter, cleared on arming, runs while the channel waits on edges.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        to_cnt_q <= '0;
      end else if (abort || arm) begin
        to_cnt_q <= '0;
      end else if (measuring && !timed_out) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
    end

    assign timed_out = measuring && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    // Channel next-state: stop beats arm, a real closing edge beats timeout.
    always_comb begin
      c_state_d = c_state_q;
      if (abort) begin
        c_state_d = C_IDLE;
      end else if (arm) begin
        c_state_d = C_ARM;
      end else begin
        case (c_state_q)
          C_ARM: begin
            if (timed_out)     c_state_d = C_DONE;
            else if (sig_edge) c_state_d = C_OPEN;
          end
          C_OPEN: begin
            if (closing || timed_out) c_state_d = C_DONE;
            else if (gate_met)        c_state_d = C_CLOSE;
          end
          C_CLOSE: begin
            if (closing || timed_out) c_state_d = C_DONE;
          end
          default: c_state_d = c_state_q;
        endcase
      end
    end

    // Channel state register and saturating signal/reference counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        c_state_q <= C_IDLE;
        sig_cnt_q <= '0;
        ref_cnt_q <= '0;
        ovf_q     <= 1'b0;
        tmo_q     <= 1'b0;
      end else begin
        c_state_q <= c_state_d;
        if (abort || arm) begin
          sig_cnt_q <= '0;
          ref_cnt_q <= '0;
          ovf_q     <= 1'b0;
          tmo_q     <= 1'b0;
        end else begin
          case (c_state_q)
            C_ARM: begin
              if (timed_out) begin
                tmo_q <= 1'b1;
              end else if (sig_edge) begin
                sig_cnt_q <= '0;
                ref_cnt_q <= CNT_WIDTH'(1);
              end
            end
            C_OPEN, C_CLOSE: begin
              if (timed_out && !closing) begin
                sig_cnt_q <= '0;
                ref_cnt_q <= '0;
                ovf_q     <= 1'b0;
                tmo_q     <= 1'b1;
              end else begin
                if (sig_edge) begin
                  if (sig_cnt_q == CNT_MAX) ovf_q <= 1'b1;
                  else                      sig_cnt_q <= sig_cnt_q + CNT_WIDTH'(1);
                end
                // The closing cycle freezes ref at t1 - t0.
                if (!closing) begin
                  if (ref_cnt_q == CNT_MAX) ovf_q <= 1'b1;
                  else                      ref_cnt_q <= ref_cnt_q + CNT_WIDTH'(1);
                end
              end
            end
            default: ;
          endcase
        end
      end
    end

    assign ch_done[c]  = (c_state_q == C_DONE);
    assign ch_sig[c]   = sig_cnt_q;
    assign ch_ref[c]   = ref_cnt_q;
    assign ch_flags[c] = {tmo_q, ovf_q};
  end

  // Top state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Top next-state; arm re-arms every channel on start or continuous restart.
  always_comb begin
    state_d = state_q;
    arm     = 1'b0;
    if (stop_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = GATE;
            arm     = 1'b1;
          end
        end
        GATE: begin
          if (&ch_done) state_d = DRAIN;
        end
        DRAIN: begin
          if (accept && last_ch) begin
            if (cont_i) begin
              state_d = GATE;
              arm     = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Gate length is captured only on a start from IDLE; zero means one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gate_q <= '0;
    end else if ((state_q == IDLE) && start_i && !stop_i) begin
      gate_q <= (gate_time_i == '0) ? CNT_WIDTH'(1) : gate_time_i;
    end
  end

  // Drain pointer walks the channels, one step per accepted result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ch_q <= '0;
    end else if ((state_q != DRAIN) || stop_i) begin
      rd_ch_q <= '0;
    end else if (accept) begin
      rd_ch_q <= last_ch ? '0 : rd_ch_q + CH_W'(1);
    end
  end

  assign busy_o          = (state_q != IDLE);
  assign res.res_valid_o = (state_q == DRAIN);
  assign res.res_ch_o    = res.res_valid_o ? rd_ch_q           : '0;
  assign res.res_sig_o   = res.res_valid_o ? ch_sig[rd_ch_q]   : '0;
  assign res.res_ref_o   = res.res_valid_o ? ch_ref[rd_ch_q]   : '0;
  assign res.res_flags_o = res.res_valid_o ? ch_flags[rd_ch_q] : '0;

endmodule
